trace_capture: RTL and testbench
================================

TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 640, meaning samples per captured trace (one per display column).
REQ-002 SHALL have parameter AUTO_TIMEOUT, default 1048576, meaning clk cycles in WAIT_TRIG before an auto trigger is forced.
REQ-003 SHALL have parameter HOLDOFF, default 65536, meaning clk cycles spent in HOLDOFF after a capture.
REQ-004 SHALL have port clk  in  1  50 MHz system clock; all logic is in this single clock domain.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports sample_valid  in  1  and sample  in  12, an unsigned ADC sample qualified by sample_valid.
REQ-007 SHALL have port trig_level  in  12  rising-edge trigger threshold.
REQ-008 SHALL have ports run  in  1  (continuous re-arm), arm  in  1  (single-shot arm pulse) and trig_auto  in  1  (auto-trigger enable).
REQ-009 SHALL have ports raddr  in  10  and rdata  out  9, the display read port returning the trace row (0..479).
REQ-010 SHALL have ports busy  out  1, trig_pulse  out  1, done_pulse  out  1 and auto_fired  out  1.

Function
REQ-011 SHALL implement the states IDLE, WAIT_TRIG, CAPTURE and HOLDOFF.
REQ-012 IDLE SHALL go to WAIT_TRIG on the clk after run=1 or arm=1 is seen; otherwise it stays in IDLE.
REQ-013 WAIT_TRIG SHALL trigger on a valid sample where prev < trig_level and cur >= trig_level; prev is the last valid sample seen in WAIT_TRIG, so the first valid sample after entry never triggers.
REQ-014 With trig_auto=1, after AUTO_TIMEOUT clk cycles in WAIT_TRIG with no trigger, the next valid sample SHALL trigger unconditionally and set auto_fired; a real trigger clears auto_fired.
REQ-015 The triggering sample SHALL be written at address 0, and each following valid sample at the next address, up to DEPTH-1.
REQ-016 trig_pulse SHALL be high for exactly one clk, in the cycle the triggering sample is accepted.
REQ-017 After address DEPTH-1 is written, the block SHALL enter HOLDOFF and assert done_pulse for one clk.
REQ-018 HOLDOFF SHALL last exactly HOLDOFF clk cycles, ignore arm, then return to IDLE; with run=1 it then re-arms per REQ-012.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 Scaling SHALL be y = 479 - min(sample>>3, 479), giving a 9-bit value: full scale maps to row 0 and zero maps to row 479.
REQ-021 rdata SHALL be registered with one-clk latency from raddr; raddr >= DEPTH SHALL return 0.
REQ-022 A read and a write to the same address in the same clk SHALL return the old contents.
REQ-023 The read port SHALL stay live in all states; tearing during CAPTURE is accepted.
REQ-024 sample_valid=0 SHALL stall the address counter and the trigger history, with no write.

Reset
REQ-025 rst_n=0 SHALL asynchronously force: state IDLE, write address 0, timeout and holdoff counters 0, prev 0, rdata 0, and busy, trig_pulse, done_pulse and auto_fired all 0.
REQ-026 Reset mid-CAPTURE SHALL abandon the trace; RAM contents are not cleared, and partial data remains readable.
REQ-027 Logic SHALL leave reset on the first clk edge after rst_n rises, with no extra synchronisation inside the block.

Structure
REQ-028 Package trace_pkg SHALL hold the state enum, YMAX=479, the TRACE_AW=10 and TRACE_DW=9 widths, and the DEPTH default.
REQ-029 Sub-module trace_ram SHALL be a 1024x9 simple dual-port RAM (one write port, one registered read port) that infers block RAM and has no reset on its array.
REQ-030 All counters SHALL be sized from the parameters via $clog2; arithmetic SHALL be unsigned and SHALL never wrap past DEPTH-1.

Verification
REQ-031 Ramp sample 0..4095 with trig_level=2048 and run=1 -> trig_pulse on the sample 2048, addr 0 holds 223, and done_pulse comes 639 valid samples later.
REQ-032 Constant sample=4095 with trig_auto=1 and AUTO_TIMEOUT=16 -> auto trigger on the first valid sample after 16 clks, auto_fired=1, and all 640 entries equal 0.
REQ-033 Falling-only signal with trig_auto=0 -> the block stays in WAIT_TRIG, busy=1, and no writes occur.
REQ-034 run=0 with an arm pulse -> exactly one capture, then IDLE after HOLDOFF; a second arm pulse during HOLDOFF is ignored.
REQ-035 raddr=700 -> rdata=0 one clk later; a same-address read/write returns the old value.
REQ-036 rst_n low at write address 300 -> all outputs 0 asynchronously; after release the block re-arms and overwrites from address 0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and constants for the oscilloscope trace capture block.
// Sample-to-row scaling lives here so the capture path and any display logic agree.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_TRIG,
        ST_CAPTURE,
        ST_HOLDOFF
    } state_t;

    localparam int YMAX          = 479;
    localparam int TRACE_AW      = 10;
    localparam int TRACE_DW      = 9;
    localparam int DEPTH_DEFAULT = 640;

    // Full scale lands on row 0 and zero lands on the bottom row.
    function automatic logic [TRACE_DW-1:0] scaleSample(input logic [11:0] s);
        logic [TRACE_DW-1:0] coarse;
        coarse = TRACE_DW'(s >> 3);
        if (coarse > TRACE_DW'(YMAX)) begin
            coarse = TRACE_DW'(YMAX);
        end
        return TRACE_DW'(YMAX) - coarse;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// 1024x9 simple dual-port trace memory: one write port, one registered read port.
// Read-during-write to the same address returns the previous contents.
module trace_ram
    import trace_pkg::*;
(
    input  logic                clk,
    input  logic                we,
    input  logic [TRACE_AW-1:0] waddr,
    input  logic [TRACE_DW-1:0] wdata,
    input  logic [TRACE_AW-1:0] raddr,
    output logic [TRACE_DW-1:0] rdata
);

    logic [TRACE_DW-1:0] mem [0:(1 << TRACE_AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/trace_capture.sv
// Triggered single-trace capture: waits for a rising crossing (or auto timeout),
// stores DEPTH scaled samples, then holds off before it may re-arm.
module trace_capture
    import trace_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEFAULT,
    parameter int AUTO_TIMEOUT = 1048576,
    parameter int HOLDOFF      = 65536
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_valid,
    input  logic [11:0]         sample,
    input  logic [11:0]         trig_level,
    input  logic                run,
    input  logic                arm,
    input  logic                trig_auto,
    input  logic [TRACE_AW-1:0] raddr,
    output logic [TRACE_DW-1:0] rdata,
    output logic                busy,
    output logic                trig_pulse,
    output logic                done_pulse,
    output logic                auto_fired
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TO_W = (AUTO_TIMEOUT > 0) ? $clog2(AUTO_TIMEOUT + 1) : 1;
    localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    localparam logic [AW-1:0]       LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [TO_W-1:0]     TO_MAX    = TO_W'(AUTO_TIMEOUT);
    localparam logic [HO_W-1:0]     HO_LAST   = HO_W'(HOLDOFF - 1);
    localparam logic [TRACE_AW:0]   DEPTH_W   = (TRACE_AW + 1)'(DEPTH);

    state_t               stateReg;
    logic [AW-1:0]        wrAddr;
    logic [TO_W-1:0]      toCnt;
    logic [HO_W-1:0]      hoCnt;
    logic [11:0]          prevSample;
    logic                 prevValid;
    logic                 rangeOkReg;

    logic                 timedOut;
    logic                 realEdge;
    logic                 trigHit;
    logic                 ramWe;
    logic [TRACE_AW-1:0]  ramWaddr;
    logic [TRACE_DW-1:0]  ramQ;

    // prevValid keeps the first valid sample after arming from comparing against stale history.
    assign timedOut = trig_auto && (toCnt == TO_MAX);
    assign realEdge = prevValid && (prevSample < trig_level) && (sample >= trig_level);
    assign trigHit  = (stateReg == ST_WAIT_TRIG) && sample_valid && (realEdge || timedOut);
    assign ramWe    = trigHit || ((stateReg == ST_CAPTURE) && sample_valid);
    assign ramWaddr = trigHit ? '0 : TRACE_AW'(wrAddr);

    trace_ram u_ram (
        .clk   (clk),
        .we    (ramWe),
        .waddr (ramWaddr),
        .wdata (scaleSample(sample)),
        .raddr (raddr),
        .rdata (ramQ)
    );

    // Out-of-range reads are masked after the RAM so unwritten rows never leak out.
    assign rdata = rangeOkReg ? ramQ : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg   <= ST_IDLE;
            wrAddr     <= '0;
            toCnt      <= '0;
            hoCnt      <= '0;
            prevSample <= '0;
            prevValid  <= 1'b0;
            rangeOkReg <= 1'b0;
            busy       <= 1'b0;
            trig_pulse <= 1'b0;
            done_pulse <= 1'b0;
            auto_fired <= 1'b0;
        end else begin
            trig_pulse <= 1'b0;
            done_pulse <= 1'b0;
            rangeOkReg <= ({1'b0, raddr} < DEPTH_W);
            case (stateReg)
                ST_IDLE: begin
                    if (run || arm) begin
                        stateReg  <= ST_WAIT_TRIG;
                        busy      <= 1'b1;
                        toCnt     <= '0;
                        prevValid <= 1'b0;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (toCnt != TO_MAX) begin
                        toCnt <= toCnt + TO_W'(1);
                    end
                    if (trigHit) begin
                        trig_pulse <= 1'b1;
                        auto_fired <= !realEdge;
                        if (LAST_ADDR == '0) begin
                            stateReg   <= ST_HOLDOFF;
                            done_pulse <= 1'b1;
                            hoCnt      <= '0;
                            wrAddr     <= '0;
                        end else begin
                            stateReg <= ST_CAPTURE;
                            wrAddr   <= AW'(1);
                        end
                    end else if (sample_valid) begin
                        prevSample <= sample;
                        prevValid  <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (sample_valid) begin
                        if (wrAddr == LAST_ADDR) begin
                            stateReg   <= ST_HOLDOFF;
                            done_pulse <= 1'b1;
                            hoCnt      <= '0;
                            wrAddr     <= '0;
                        end else begin
                            wrAddr <= wrAddr + AW'(1);
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (hoCnt == HO_LAST) begin
                        stateReg <= ST_IDLE;
                        busy     <= 1'b0;
                        hoCnt    <= '0;
                    end else begin
                        hoCnt <= hoCnt + HO_W'(1);
                    end
                end
                default: begin
                    stateReg <= ST_IDLE;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: ramp trigger, auto trigger, no-trigger,
// read port behaviour and reset in the middle of a capture.
module tb_trace_capture;

    localparam int DEPTH        = 640;
    localparam int AUTO_TIMEOUT = 16;
    localparam int HOLDOFF      = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] sample = '0;
    logic [11:0] trig_level = '0;
    logic        run = 1'b0;
    logic        arm = 1'b0;
    logic        trig_auto = 1'b0;
    logic [9:0]  raddr = '0;
    logic [8:0]  rdata;
    logic        busy;
    logic        trig_pulse;
    logic        done_pulse;
    logic        auto_fired;

    int passCount = 0;
    int checkCount = 0;

    trace_capture #(
        .DEPTH        (DEPTH),
        .AUTO_TIMEOUT (AUTO_TIMEOUT),
        .HOLDOFF      (HOLDOFF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .trig_level   (trig_level),
        .run          (run),
        .arm          (arm),
        .trig_auto    (trig_auto),
        .raddr        (raddr),
        .rdata        (rdata),
        .busy         (busy),
        .trig_pulse   (trig_pulse),
        .done_pulse   (done_pulse),
        .auto_fired   (auto_fired)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic readAddr(input logic [9:0] a, output logic [8:0] d);
        sample_valid = 1'b0;
        raddr = a;
        tick();
        d = rdata;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checkCount++;
        if ({busy, trig_pulse, done_pulse, auto_fired} !== 4'b0000)
            $display("FAIL reset_flags: got %b expected 0000", {busy, trig_pulse, done_pulse, auto_fired});
        else passCount++;
        checkCount++;
        if (rdata !== 9'd0) $display("FAIL reset_rdata: got %0d expected 0", rdata);
        else passCount++;
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        checkCount++;
        if (busy !== 1'b0) $display("FAIL idle_stays: busy got %b expected 0", busy);
        else passCount++;
        $display("reset: flags=%b rdata=%0d", {busy, trig_pulse, done_pulse, auto_fired}, rdata);
    endtask

    task automatic test_ramp();
        int trigK = -1;
        int doneK = -1;
        int trigs = 0;
        trig_level = 12'd2048;
        trig_auto = 1'b0;
        run = 1'b1;
        tick();
        checkCount++;
        if (busy !== 1'b1) $display("FAIL ramp_arm_busy: got %b expected 1", busy);
        else passCount++;
        for (int k = 0; k < 4096; k++) begin
            sample = 12'(k);
            sample_valid = 1'b1;
            tick();
            if (trig_pulse) begin
                trigs++;
                trigK = k;
            end
            if (done_pulse) begin
                doneK = k;
                break;
            end
        end
        run = 1'b0;
        sample_valid = 1'b0;
        checkCount++;
        if (trigK !== 2048) $display("FAIL ramp_trig_sample: got %0d expected 2048", trigK);
        else passCount++;
        checkCount++;
        if (trigs !== 1) $display("FAIL ramp_trig_count: got %0d expected 1", trigs);
        else passCount++;
        checkCount++;
        if (doneK !== 2687) $display("FAIL ramp_done_sample: got %0d expected 2687", doneK);
        else passCount++;
        tick();
        checkCount++;
        if (done_pulse !== 1'b0) $display("FAIL done_one_clk: got %b expected 0", done_pulse);
        else passCount++;
        for (int i = 0; i < 30; i++) tick();
        checkCount++;
        if (busy !== 1'b1) $display("FAIL holdoff_last_cycle: busy got %b expected 1", busy);
        else passCount++;
        tick();
        checkCount++;
        if (busy !== 1'b0) $display("FAIL holdoff_exit: busy got %b expected 0", busy);
        else passCount++;
        $display("ramp: trig at sample %0d, done at sample %0d", trigK, doneK);
    endtask

    task automatic test_read();
        logic [8:0] d;
        readAddr(10'd0, d);
        checkCount++;
        if (d !== 9'd223) $display("FAIL read_addr0: got %0d expected 223", d);
        else passCount++;
        readAddr(10'd1, d);
        checkCount++;
        if (d !== 9'd223) $display("FAIL read_addr1: got %0d expected 223", d);
        else passCount++;
        readAddr(10'd8, d);
        checkCount++;
        if (d !== 9'd222) $display("FAIL read_addr8: got %0d expected 222", d);
        else passCount++;
        readAddr(10'd639, d);
        checkCount++;
        if (d !== 9'd144) $display("FAIL read_addr639: got %0d expected 144", d);
        else passCount++;
        readAddr(10'd640, d);
        checkCount++;
        if (d !== 9'd0) $display("FAIL read_addr640: got %0d expected 0", d);
        else passCount++;
        readAddr(10'd700, d);
        checkCount++;
        if (d !== 9'd0) $display("FAIL read_addr700: got %0d expected 0", d);
        else passCount++;
        $display("read: addr700 -> %0d", d);
    endtask

    task automatic test_auto_trigger();
        int trigT = -1;
        int doneT = -1;
        int extra = 0;
        int bad = 0;
        logic [8:0] d;
        trig_auto = 1'b1;
        trig_level = 12'd2048;
        sample = 12'd4095;
        sample_valid = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        checkCount++;
        if (busy !== 1'b1) $display("FAIL auto_arm_busy: got %b expected 1", busy);
        else passCount++;
        sample_valid = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (trig_pulse) begin
                trigT = t;
                break;
            end
        end
        checkCount++;
        if (trigT !== 17) $display("FAIL auto_trig_cycle: got %0d expected 17", trigT);
        else passCount++;
        checkCount++;
        if (auto_fired !== 1'b1) $display("FAIL auto_fired_set: got %b expected 1", auto_fired);
        else passCount++;
        for (int t = 1; t <= 700; t++) begin
            tick();
            if (done_pulse) begin
                doneT = t;
                break;
            end
        end
        checkCount++;
        if (doneT !== 639) $display("FAIL auto_done_cycle: got %0d expected 639", doneT);
        else passCount++;
        sample_valid = 1'b0;
        for (int t = 1; t <= 60; t++) begin
            arm = (t == 6);
            tick();
            if (trig_pulse) extra++;
        end
        arm = 1'b0;
        checkCount++;
        if (busy !== 1'b0) $display("FAIL arm_in_holdoff_ignored: busy got %b expected 0", busy);
        else passCount++;
        checkCount++;
        if (extra !== 0) $display("FAIL single_shot: extra triggers got %0d expected 0", extra);
        else passCount++;
        for (int a = 0; a < DEPTH; a++) begin
            readAddr(10'(a), d);
            if (d !== 9'd0) bad++;
        end
        checkCount++;
        if (bad !== 0) $display("FAIL auto_all_zero: nonzero entries got %0d expected 0", bad);
        else passCount++;
        $display("auto: trig after %0d clks, done after %0d samples", trigT, doneT);
    endtask

    task automatic test_no_trigger();
        int trigs = 0;
        logic [8:0] d;
        trig_auto = 1'b0;
        trig_level = 12'd2048;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (i % 4 == 3) begin
                sample_valid = 1'b0;
                sample = 12'd0;
            end else begin
                sample_valid = 1'b1;
                sample = 12'(3000 - 10 * i);
            end
            tick();
            if (trig_pulse) trigs++;
        end
        sample_valid = 1'b0;
        checkCount++;
        if (trigs !== 0) $display("FAIL falling_no_trig: got %0d expected 0", trigs);
        else passCount++;
        checkCount++;
        if (busy !== 1'b1) $display("FAIL falling_busy: got %b expected 1", busy);
        else passCount++;
        checkCount++;
        if (auto_fired !== 1'b1) $display("FAIL auto_fired_held: got %b expected 1", auto_fired);
        else passCount++;
        readAddr(10'd0, d);
        checkCount++;
        if (d !== 9'd0) $display("FAIL falling_no_write0: got %0d expected 0", d);
        else passCount++;
        readAddr(10'd1, d);
        checkCount++;
        if (d !== 9'd0) $display("FAIL falling_no_write1: got %0d expected 0", d);
        else passCount++;
        $display("falling: %0d triggers, busy=%b", trigs, busy);
    endtask

    task automatic test_reset_mid_capture();
        logic [8:0] d;
        trig_level = 12'd100;
        sample = 12'd0;
        sample_valid = 1'b1;
        tick();
        sample = 12'd800;
        tick();
        checkCount++;
        if (trig_pulse !== 1'b1) $display("FAIL real_trig: got %b expected 1", trig_pulse);
        else passCount++;
        checkCount++;
        if (auto_fired !== 1'b0) $display("FAIL auto_fired_clear: got %b expected 0", auto_fired);
        else passCount++;
        for (int a = 1; a < 300; a++) begin
            sample = 12'(8 * a);
            sample_valid = 1'b1;
            if (a == 5) raddr = 10'd5;
            if (a == 7) raddr = 10'd0;
            tick();
            if (a == 5) begin
                checkCount++;
                if (rdata !== 9'd0) $display("FAIL rd_wr_same_old: got %0d expected 0", rdata);
                else passCount++;
            end
            if (a == 6) begin
                checkCount++;
                if (rdata !== 9'd474) $display("FAIL rd_after_wr: got %0d expected 474", rdata);
                else passCount++;
            end
        end
        sample_valid = 1'b0;
        checkCount++;
        if (rdata !== 9'd379) $display("FAIL pre_reset_rdata: got %0d expected 379", rdata);
        else passCount++;
        rst_n = 1'b0;
        #2;
        checkCount++;
        if (rdata !== 9'd0) $display("FAIL async_reset_rdata: got %0d expected 0", rdata);
        else passCount++;
        checkCount++;
        if ({busy, trig_pulse, done_pulse, auto_fired} !== 4'b0000)
            $display("FAIL async_reset_flags: got %b expected 0000", {busy, trig_pulse, done_pulse, auto_fired});
        else passCount++;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        readAddr(10'd0, d);
        checkCount++;
        if (d !== 9'd379) $display("FAIL partial_addr0: got %0d expected 379", d);
        else passCount++;
        readAddr(10'd299, d);
        checkCount++;
        if (d !== 9'd180) $display("FAIL partial_addr299: got %0d expected 180", d);
        else passCount++;
        readAddr(10'd300, d);
        checkCount++;
        if (d !== 9'd0) $display("FAIL partial_addr300: got %0d expected 0", d);
        else passCount++;
        run = 1'b1;
        tick();
        checkCount++;
        if (busy !== 1'b1) $display("FAIL rearm_busy: got %b expected 1", busy);
        else passCount++;
        sample = 12'd0;
        sample_valid = 1'b1;
        tick();
        sample = 12'd200;
        tick();
        checkCount++;
        if (trig_pulse !== 1'b1) $display("FAIL rearm_trig: got %b expected 1", trig_pulse);
        else passCount++;
        sample = 12'd4000;
        tick();
        run = 1'b0;
        sample_valid = 1'b0;
        readAddr(10'd0, d);
        checkCount++;
        if (d !== 9'd454) $display("FAIL overwrite_addr0: got %0d expected 454", d);
        else passCount++;
        readAddr(10'd1, d);
        checkCount++;
        if (d !== 9'd0) $display("FAIL overwrite_addr1: got %0d expected 0", d);
        else passCount++;
        readAddr(10'd2, d);
        checkCount++;
        if (d !== 9'd477) $display("FAIL stall_keeps_addr2: got %0d expected 477", d);
        else passCount++;
        $display("reset_mid: re-armed, addr0=%0d", 454);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passCount, checkCount);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ramp();
        test_read();
        test_auto_trigger();
        test_no_trigger();
        test_reset_mid_capture();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
